// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
// Holds widths, FSM encodings and the rotating-priority pick.
package arb_defs;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_sel_decoder.sv
// 3:8 select decoder with enable.
// Produces the one-hot grant from the registered select index.
module sel_decoder_3to8
    import arb_defs::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (en) begin
            gnt[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter granting one of 8 requesters a shared decoded select.
// Grants are held until done, request drop, or hold timeout.
module rr_decoder_arbiter
    import arb_defs::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [SEL_W-1:0] SEL,
    output logic [N_REQ-1:0] GNT,
    output logic             VALID,
    output logic             TOUT
);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              tout_q, tout_d;

    logic rel_done;
    logic rel_drop;
    logic rel_tout;

    assign rel_done = DONE;
    assign rel_drop = !REQ[sel_q];
    assign rel_tout = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        tout_d  = 1'b0;
        case (state_q)
            // GAP already has GNT low, so it may arbitrate for the next grant
            ST_IDLE, ST_GAP: begin
                if (|REQ) begin
                    sel_d   = rr_pick(REQ, ptr_q);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_tout) begin
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 1'b1;
                    cnt_d   = '0;
                    tout_d  = rel_tout && !rel_done && !rel_drop;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
        end
    end

    sel_decoder_3to8 u_dec (
        .sel (sel_q),
        .en  (valid_q),
        .gnt (GNT)
    );

    assign SEL   = sel_q;
    assign VALID = valid_q;
    assign TOUT  = tout_q;

endmodule
